// File: rtl/vga_fill_engine_if.sv
// Bus bundle between the fill engine and the host / VGA memory port.
// Active-low VGA strobes carry an _n suffix.
interface vga_fill_engine_if;
    // host control
    logic        start;
    logic        abort;
    logic [16:0] start_addr;
    logic [16:0] byte_count;
    logic [7:0]  fill_value;
    // VGA wait line
    logic        rdy;
    // VGA memory port
    logic [16:0] vga_addr;
    logic        vga_mem_n;
    logic        wr_n;
    logic        rd_n;
    logic        bhe_n;
    logic [15:0] data_out;
    logic        data_oe;
    // status
    logic        busy;
    logic        done;
    logic        error;

    // engine side: drives the VGA port and status
    modport master (
        input  start, abort, start_addr, byte_count, fill_value, rdy,
        output vga_addr, vga_mem_n, wr_n, rd_n, bhe_n, data_out, data_oe,
        output busy, done, error
    );

    // host / memory side
    modport slave (
        output start, abort, start_addr, byte_count, fill_value, rdy,
        input  vga_addr, vga_mem_n, wr_n, rd_n, bhe_n, data_out, data_oe,
        input  busy, done, error
    );
endinterface

// File: rtl/vga_fill_engine.sv
// VGA fill engine: writes a constant byte over a range of the 128 KB VGA
// window using 8086-style byte/word write cycles, honouring rdy wait states.
module vga_fill_engine #(
    parameter int SETUP_CYC   = 2,
    parameter int WR_HOLD     = 4,
    parameter int RECOVER_CYC = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    vga_fill_engine_if.master   bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    // HOLD is the first recovery clock: _wr released, select/addr/data kept.
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER, FINISH} state_e;

    state_e        state_q, state_d;
    logic [16:0]   addr_q, addr_d;
    logic [16:0]   rem_q, rem_d;
    logic [7:0]    fill_q, fill_d;
    logic          bhe_q, bhe_d;      // active low, per bus cycle
    logic [1:0]    step_q, step_d;
    logic [3:0]    cnt_q, cnt_d;      // SETUP / RECOVER phase counter
    logic [3:0]    hold_q, hold_d;    // consecutive rdy=1 clocks in STROBE
    logic [TW-1:0] to_q, to_d;        // clocks spent in STROBE
    logic          err_q, err_d;
    logic          rdy_q;
    logic          on_bus;

    // Cycle type from address and remaining count: {bhe_n, step}.
    // Odd address -> high byte; even with one byte left -> low byte; else word.
    function automatic logic [2:0] cyc_kind(input logic [16:0] a, input logic [16:0] n);
        if (a[0])            return {1'b0, 2'd1};
        else if (n == 17'd1) return {1'b1, 2'd1};
        else                 return {1'b0, 2'd2};
    endfunction

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        bhe_d   = bhe_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        to_d    = to_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d = bus.start_addr;
                    rem_d  = bus.byte_count;
                    fill_d = bus.fill_value;
                    err_d  = 1'b0;
                    cnt_d  = '0;
                    if (bus.byte_count == 17'd0) begin
                        state_d = FINISH;
                    end else begin
                        {bhe_d, step_d} = cyc_kind(bus.start_addr, bus.byte_count);
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    hold_d  = '0;
                    to_d    = '0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                hold_d = rdy_q ? hold_q + 4'd1 : 4'd0;
                to_d   = to_q + 1'b1;
                if (rdy_q && hold_q == 4'(WR_HOLD - 1)) begin
                    state_d = HOLD;
                end else if (to_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            HOLD: begin
                // address wraps naturally at 17 bits
                addr_d  = addr_q + 17'(step_q);
                rem_d   = rem_q - 17'(step_q);
                cnt_d   = '0;
                state_d = RECOVER;
            end
            RECOVER: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(RECOVER_CYC - 1)) begin
                    cnt_d = '0;
                    if (rem_q == 17'd0) begin
                        state_d = FINISH;
                    end else begin
                        {bhe_d, step_d} = cyc_kind(addr_q, rem_q);
                        state_d = SETUP;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort only takes effect once the engine has left IDLE, so a
        // start in the same clock still wins
        if (bus.abort && state_q != IDLE) begin
            err_d = 1'b1;
            if (state_q != FINISH) state_d = FINISH;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            fill_q  <= '0;
            bhe_q   <= 1'b1;
            step_q  <= 2'd0;
            cnt_q   <= '0;
            hold_q  <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            bhe_q   <= bhe_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            err_q   <= err_d;
            rdy_q   <= bus.rdy;
        end
    end

    // Outputs decode straight from registers so async reset clears them at once
    assign on_bus        = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    assign bus.vga_addr  = addr_q;
    assign bus.vga_mem_n = !on_bus;
    assign bus.wr_n      = (state_q != STROBE);
    assign bus.rd_n      = 1'b1;
    assign bus.bhe_n     = on_bus ? bhe_q : 1'b1;
    assign bus.data_out  = {fill_q, fill_q};
    assign bus.data_oe   = on_bus;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FINISH);
    assign bus.error     = err_q;
endmodule

// File: tb/tb_vga_fill_engine.sv
// Scoreboard bench for vga_fill_engine: directed transfers push expected bus
// cycles and done pulses; a monitor reconstructs them from the pins and checks.
module tb_vga_fill_engine;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   t0 = 0;
    int   done_cnt = 0;
    int   done_base = 0;
    int   errors = 0;
    int   checks = 0;
    int   rd_low = 0;
    int   bus_bad = 0;

    vga_fill_engine_if bus ();

    vga_fill_engine dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0: one bus cycle seen between _vga_mem fall and rise
    // kind 1: a done pulse, with error and edges since the start edge
    typedef struct packed {
        logic        kind;
        logic [16:0] addr;
        logic        bhe;
        logic [15:0] data;
        int          memlow;
        int          wrlow;
        logic        ok;
        logic        err;
        int          delta;
    } ev_t;

    ev_t   exp_q[$];
    string tag_q[$];

    function automatic ev_t mk_wr(logic [16:0] a, logic b, logic [15:0] d, int ml, int wl);
        ev_t e;
        e = '0;
        e.addr = a; e.bhe = b; e.data = d; e.memlow = ml; e.wrlow = wl; e.ok = 1'b1;
        return e;
    endfunction

    function automatic ev_t mk_done(logic er, int dl);
        ev_t e;
        e = '0;
        e.kind = 1'b1; e.err = er; e.delta = dl;
        return e;
    endfunction

    function automatic string fmt(ev_t e);
        return $sformatf("kind=%0d addr=%h bhe=%b data=%h memlow=%0d wrlow=%0d ok=%b err=%b delta=%0d",
                         e.kind, e.addr, e.bhe, e.data, e.memlow, e.wrlow, e.ok, e.err, e.delta);
    endfunction

    task automatic expect_ev(input ev_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check(input ev_t act);
        ev_t   e;
        string tg;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s, required none", fmt(act));
        end else begin
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %s, required %s", tg, fmt(act), fmt(e));
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Monitor: rebuild bus cycles and done pulses from the pins
    logic        prev_mem_n = 1'b1;
    int          ml, wl;
    logic [16:0] c_addr;
    logic        c_bhe;
    logic [15:0] c_data;
    logic        c_ok;
    initial begin : monitor
        ev_t act;
        forever begin
            @(negedge clk);
            if (!bus.rd_n) rd_low++;
            if (bus.vga_mem_n && (!bus.wr_n || bus.data_oe || !bus.bhe_n)) bus_bad++;
            if (!bus.vga_mem_n) begin
                if (prev_mem_n) begin
                    ml = 0; wl = 0;
                    c_addr = bus.vga_addr; c_bhe = bus.bhe_n; c_data = bus.data_out; c_ok = 1'b1;
                end
                ml++;
                if (!bus.wr_n) wl++;
                if (bus.vga_addr != c_addr || bus.bhe_n != c_bhe || bus.data_out != c_data || !bus.data_oe)
                    c_ok = 1'b0;
            end else if (!prev_mem_n) begin
                act = mk_wr(c_addr, c_bhe, c_data, ml, wl);
                act.ok = c_ok;
                sb_check(act);
            end
            if (bus.done) begin
                sb_check(mk_done(bus.error, cyc - t0));
                done_cnt++;
            end
            prev_mem_n = bus.vga_mem_n;
        end
    end

    task automatic start_xfer(input logic [16:0] a, input logic [16:0] n, input logic [7:0] f);
        @(negedge clk);
        bus.start_addr = a;
        bus.byte_count = n;
        bus.fill_value = f;
        bus.start      = 1'b1;
        t0             = cyc + 1;
        done_base      = done_cnt;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == done_base) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got no done after %0d clocks, required a done pulse", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "_addr"},  32'(bus.vga_addr), 32'h0);
        chk({p, "_mem_n"}, 32'(bus.vga_mem_n), 32'h1);
        chk({p, "_wr_n"},  32'(bus.wr_n), 32'h1);
        chk({p, "_rd_n"},  32'(bus.rd_n), 32'h1);
        chk({p, "_bhe_n"}, 32'(bus.bhe_n), 32'h1);
        chk({p, "_oe"},    32'(bus.data_oe), 32'h0);
        chk({p, "_busy"},  32'(bus.busy), 32'h0);
        chk({p, "_done"},  32'(bus.done), 32'h0);
        chk({p, "_error"}, 32'(bus.error), 32'h0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.start_addr = '0;
        bus.byte_count = '0;
        bus.fill_value = '0;
        bus.rdy        = 1'b1;
        #3;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // two aligned words, 9 clocks each
        expect_ev(mk_wr(17'h00100, 1'b0, 16'hA5A5, 7, 4), "t1_word0");
        expect_ev(mk_wr(17'h00102, 1'b0, 16'hA5A5, 7, 4), "t1_word1");
        expect_ev(mk_done(1'b0, 18), "t1_done");
        start_xfer(17'h00100, 17'd4, 8'hA5);
        wait_done("t1", 200);

        // odd start: high byte, word, low byte
        expect_ev(mk_wr(17'h00101, 1'b0, 16'h5A5A, 7, 4), "t2_hibyte");
        expect_ev(mk_wr(17'h00102, 1'b0, 16'h5A5A, 7, 4), "t2_word");
        expect_ev(mk_wr(17'h00104, 1'b1, 16'h5A5A, 7, 4), "t2_lobyte");
        expect_ev(mk_done(1'b0, 27), "t2_done");
        start_xfer(17'h00101, 17'd4, 8'h5A);
        wait_done("t2", 200);

        // rdy low 6 clocks mid-strobe: strobe 1 + 6 + 4 = 11 clocks
        expect_ev(mk_wr(17'h00200, 1'b0, 16'hC3C3, 14, 11), "t3_wait_word");
        expect_ev(mk_done(1'b0, 16), "t3_done");
        start_xfer(17'h00200, 17'd2, 8'hC3);
        repeat (2) @(negedge clk);
        bus.rdy = 1'b0;
        repeat (6) @(negedge clk);
        bus.rdy = 1'b1;
        wait_done("t3", 200);

        // address wrap at the top of the window
        expect_ev(mk_wr(17'h1FFFE, 1'b0, 16'h1111, 7, 4), "t4_top_word");
        expect_ev(mk_wr(17'h00000, 1'b0, 16'h1111, 7, 4), "t4_wrap_word");
        expect_ev(mk_done(1'b0, 18), "t4_done");
        start_xfer(17'h1FFFE, 17'd4, 8'h11);
        wait_done("t4", 200);

        // rdy stuck low: timeout after 1023 strobe clocks
        bus.rdy = 1'b0;
        expect_ev(mk_wr(17'h00300, 1'b0, 16'h6666, 1025, 1023), "t5_timeout_cycle");
        expect_ev(mk_done(1'b1, 1025), "t5_timeout_done");
        start_xfer(17'h00300, 17'd2, 8'h66);
        wait_done("t5", 2000);
        bus.rdy = 1'b1;
        chk("t5_error_sticky", 32'(bus.error), 32'h1);

        // zero count: done right away, no bus activity, error cleared
        expect_ev(mk_done(1'b0, 0), "t5_zero_done");
        start_xfer(17'h00300, 17'd0, 8'h99);
        wait_done("t5z", 50);
        chk("t5z_busy", 32'(bus.busy), 32'h0);

        // abort in the second of three words
        expect_ev(mk_wr(17'h00400, 1'b0, 16'h3C3C, 7, 4), "t6_word0");
        expect_ev(mk_wr(17'h00402, 1'b0, 16'h3C3C, 3, 1), "t6_aborted_word");
        expect_ev(mk_done(1'b1, 12), "t6_abort_done");
        start_xfer(17'h00400, 17'd6, 8'h3C);
        repeat (11) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_done("t6", 200);
        chk("t6_error_sticky", 32'(bus.error), 32'h1);

        // async reset in the middle of a strobe
        expect_ev(mk_wr(17'h00500, 1'b0, 16'h7777, 4, 2), "t6_reset_cut_cycle");
        start_xfer(17'h00500, 17'd2, 8'h77);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // even address, one byte: low byte only
        expect_ev(mk_wr(17'h00600, 1'b1, 16'hE7E7, 7, 4), "t7_single_lobyte");
        expect_ev(mk_done(1'b0, 9), "t7_done");
        start_xfer(17'h00600, 17'd1, 8'hE7);
        wait_done("t7", 200);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        chk("rd_strobe_never_low", 32'(rd_low), 32'h0);
        chk("idle_bus_quiet", 32'(bus_bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
